// File: rtl/coarse_sync_pkg.sv
// Shared types and constants for the coarse sync peak search path.
// Holds the search FSM encoding, the peak/hit widths and the saturating hit helper.
package coarse_sync_pkg;

  localparam int PEAK_W       = 11;
  localparam int TS_W_DEFAULT = 32;
  localparam int HIT_W        = 8;
  localparam logic [HIT_W-1:0] HIT_SAT = {HIT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_SEARCH = 3'd2,
    ST_REPORT = 3'd3,
    ST_HOLD   = 3'd4
  } coarse_state_e;

  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
    return (v == HIT_SAT) ? v : v + HIT_W'(1);
  endfunction

endpackage

// File: rtl/coarse_peak_search_if.sv
// Correlator-side inputs and timing-stage report outputs of the coarse peak search.
// Strobes are valid-only single-cycle pulses (no ready); report fields are stable from the strobe until the next report.
interface coarse_peak_search_if #(
  parameter int OFS_W = 8,
  parameter int TS_W  = coarse_sync_pkg::TS_W_DEFAULT
);
  import coarse_sync_pkg::*;

  logic                search_arm_in;
  logic                correlate_success_in;
  logic [PEAK_W-1:0]   correlate_peak_in;
  logic [19:0]         search_timeout_in;
  logic                peak_valid_out;
  logic [PEAK_W-1:0]   peak_value_out;
  logic [OFS_W-1:0]    peak_offset_out;
  logic [TS_W-1:0]     peak_time_out;
  logic [HIT_W-1:0]    hit_count_out;
  logic                sync_timeout_out;
  logic                search_busy_out;
  coarse_state_e       state_dbg;

  modport slave (
    input  search_arm_in, correlate_success_in, correlate_peak_in, search_timeout_in,
    output peak_valid_out, peak_value_out, peak_offset_out, peak_time_out,
           hit_count_out, sync_timeout_out, search_busy_out, state_dbg
  );

  modport master (
    output search_arm_in, correlate_success_in, correlate_peak_in, search_timeout_in,
    input  peak_valid_out, peak_value_out, peak_offset_out, peak_time_out,
           hit_count_out, sync_timeout_out, search_busy_out, state_dbg
  );

endinterface

// File: rtl/coarse_peak_search_peak_tracker.sv
// Running maximum of one search window: value, offset and timestamp of the
// strongest sample (earliest wins ties) plus a saturating count of success samples.
module peak_tracker
  import coarse_sync_pkg::*;
#(
  parameter int OFS_W = 8,
  parameter int TS_W  = TS_W_DEFAULT
) (
  input  logic              logic_clk_in,
  input  logic              logic_rst_n_in,
  input  logic              clear,
  input  logic              load,
  input  logic              sample,
  input  logic [PEAK_W-1:0] peak_in,
  input  logic [OFS_W-1:0]  ofs_in,
  input  logic [TS_W-1:0]   ts_in,
  output logic [PEAK_W-1:0] max_val,
  output logic [OFS_W-1:0]  max_ofs,
  output logic [TS_W-1:0]   max_ts,
  output logic [HIT_W-1:0]  hits
);

  always_ff @(posedge logic_clk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      max_val <= '0;
      max_ofs <= '0;
      max_ts  <= '0;
      hits    <= '0;
    end else if (clear) begin
      max_val <= '0;
      max_ofs <= '0;
      max_ts  <= '0;
      hits    <= '0;
    end else if (load) begin
      // Window opener: this sample is offset 0 by definition.
      max_val <= peak_in;
      max_ofs <= '0;
      max_ts  <= ts_in;
      hits    <= HIT_W'(1);
    end else if (sample) begin
      if (peak_in > max_val) begin
        max_val <= peak_in;
        max_ofs <= ofs_in;
        max_ts  <= ts_in;
      end
      hits <= sat_inc(hits);
    end
  end

endmodule

// File: rtl/coarse_peak_search.sv
// Coarse peak search: opens a window on the first correlator hit, reports the
// strongest peak once per burst, with search timeout and post-report holdoff.
module coarse_peak_search
  import coarse_sync_pkg::*;
#(
  parameter int WIN_LEN = 64,
  parameter int OFS_W   = 8,
  parameter int HOLDOFF = 256,
  parameter int TS_W    = TS_W_DEFAULT
) (
  input  logic logic_clk_in,
  input  logic logic_rst_n_in,
  coarse_peak_search_if.slave bus
);

  localparam int HCNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  coarse_state_e      state_q, state_d;
  logic [TS_W-1:0]    ts_q;
  logic [19:0]        tmo_cnt_q;
  logic [OFS_W-1:0]   ofs_q;
  logic [HCNT_W-1:0]  hold_cnt_q;

  logic [PEAK_W-1:0]  rpt_val_q;
  logic [OFS_W-1:0]   rpt_ofs_q;
  logic [TS_W-1:0]    rpt_ts_q;
  logic [HIT_W-1:0]   rpt_hits_q;
  logic               valid_q;
  logic               tmo_q;

  logic               arm, hit, last_ofs, hold_done;
  logic               trk_clear, trk_load, trk_sample, tmo_fire, busy;
  logic [PEAK_W-1:0]  trk_val;
  logic [OFS_W-1:0]   trk_ofs;
  logic [TS_W-1:0]    trk_ts;
  logic [HIT_W-1:0]   trk_hits;

  assign arm       = bus.search_arm_in;
  assign hit       = bus.correlate_success_in;
  assign last_ofs  = (ofs_q == OFS_W'(WIN_LEN - 1));
  assign hold_done = (hold_cnt_q == HCNT_W'(HOLDOFF - 1));

  // State register
  always_ff @(posedge logic_clk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  // Next-state logic; arm deassert aborts only ARMED/SEARCH
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (arm) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!arm)     state_d = ST_IDLE;
        else if (hit) state_d = (WIN_LEN == 1) ? ST_REPORT : ST_SEARCH;
      end
      ST_SEARCH: begin
        if (!arm)          state_d = ST_IDLE;
        else if (last_ofs) state_d = ST_REPORT;
      end
      ST_REPORT: state_d = ST_HOLD;
      ST_HOLD:   if (hold_done) state_d = arm ? ST_ARMED : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    trk_clear  = 1'b0;
    trk_load   = 1'b0;
    trk_sample = 1'b0;
    tmo_fire   = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE:   trk_clear = 1'b1;
      ST_ARMED: begin
        busy     = 1'b1;
        trk_load = arm & hit;
        tmo_fire = arm & ~hit & (bus.search_timeout_in != 20'd0) &
                   (tmo_cnt_q == bus.search_timeout_in - 20'd1);
      end
      ST_SEARCH: begin
        busy       = 1'b1;
        trk_sample = arm & hit;
      end
      ST_REPORT: busy = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  always_ff @(posedge logic_clk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      ts_q       <= '0;
      tmo_cnt_q  <= '0;
      ofs_q      <= '0;
      hold_cnt_q <= '0;
      rpt_val_q  <= '0;
      rpt_ofs_q  <= '0;
      rpt_ts_q   <= '0;
      rpt_hits_q <= '0;
      valid_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_W'(1);

      // Timeout count restarts on every entry into ARMED
      if (state_q != ST_ARMED || tmo_fire) tmo_cnt_q <= '0;
      else                                 tmo_cnt_q <= tmo_cnt_q + 20'd1;

      // ofs_q is the offset of the sample taken at the next SEARCH edge
      if (state_q == ST_ARMED)       ofs_q <= OFS_W'(1);
      else if (state_q == ST_SEARCH) ofs_q <= ofs_q + OFS_W'(1);

      if (state_q == ST_HOLD) hold_cnt_q <= hold_cnt_q + HCNT_W'(1);
      else                    hold_cnt_q <= '0;

      if (state_q == ST_REPORT) begin
        rpt_val_q  <= trk_val;
        rpt_ofs_q  <= trk_ofs;
        rpt_ts_q   <= trk_ts;
        rpt_hits_q <= trk_hits;
      end
      valid_q <= (state_q == ST_REPORT);
      tmo_q   <= tmo_fire;
    end
  end

  peak_tracker #(
    .OFS_W (OFS_W),
    .TS_W  (TS_W)
  ) u_tracker (
    .logic_clk_in   (logic_clk_in),
    .logic_rst_n_in (logic_rst_n_in),
    .clear          (trk_clear),
    .load           (trk_load),
    .sample         (trk_sample),
    .peak_in        (bus.correlate_peak_in),
    .ofs_in         (ofs_q),
    .ts_in          (ts_q),
    .max_val        (trk_val),
    .max_ofs        (trk_ofs),
    .max_ts         (trk_ts),
    .hits           (trk_hits)
  );

  assign bus.peak_valid_out   = valid_q;
  assign bus.peak_value_out   = rpt_val_q;
  assign bus.peak_offset_out  = rpt_ofs_q;
  assign bus.peak_time_out    = rpt_ts_q;
  assign bus.hit_count_out    = rpt_hits_q;
  assign bus.sync_timeout_out = tmo_q;
  assign bus.search_busy_out  = busy;
  assign bus.state_dbg        = state_q;

endmodule

// File: doc/coarse_peak_search.md
Name: coarse_peak_search

Overview:
- Sits directly downstream of the four-channel coarse sync correlator.
- Consumes the per-cycle correlator decision (success flag plus 11-bit peak) and opens a fixed search window on the first threshold crossing.
- Reports the strongest peak in that window, with its offset and an absolute timestamp, to the fine-sync/timing stage.
- Provides a search timeout and a post-report holdoff so one sync burst produces exactly one report.

Parameters:
WIN_LEN, 64, number of correlator samples in one search window (1..2^OFS_W).
OFS_W, 8, width of peak offset within window.
HOLDOFF, 256, cycles after a report during which correlator hits are ignored.
TS_W, 32, width of free-running timestamp counter.

Ports:
logic_clk_in  in  1  200 MHz logic clock
logic_rst_n_in  in  1  asynchronous active-low reset
search_arm_in  in  1  level; 1 = search enabled
correlate_success_in  in  1  correlator threshold crossing this cycle
correlate_peak_in  in  11  correlator peak value, valid when success=1
search_timeout_in  in  20  ARMED timeout in cycles; 0 = no timeout
peak_valid_out  out  1  one-cycle report strobe
peak_value_out  out  11  maximum peak of last window
peak_offset_out  out  OFS_W  sample offset of maximum from window start
peak_time_out  out  TS_W  timestamp of winning sample
hit_count_out  out  8  success samples in last window, saturating at 255
sync_timeout_out  out  1  one-cycle timeout strobe
search_busy_out  out  1  1 in ARMED, SEARCH or REPORT

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, timestamp 0.
- Timestamp: free-running TS_W counter, +1 every cycle, wraps to 0.
- States: IDLE, ARMED, SEARCH, REPORT, HOLD.
- IDLE -> ARMED when search_arm_in=1; timeout counter cleared.
- ARMED:
  - On a sampled success=1, that sample is offset 0. Go to SEARCH with max=peak, offset=0, time=timestamp, hits=1.
  - If not hit and search_timeout_in!=0 and the timeout counter reaches search_timeout_in: sync_timeout_out=1 for one cycle, counter cleared, stay ARMED.
- SEARCH:
  - Samples offsets 1..WIN_LEN-1. A sample competes only if success=1.
  - Winner replaces the stored maximum only when strictly greater; ties keep the earliest.
  - hits increments on every success sample, saturating at 255.
  - After offset WIN_LEN-1 go to REPORT.
- REPORT, one cycle:
  - peak_valid_out=1.
  - peak_value_out, peak_offset_out, peak_time_out and hit_count_out update in this same cycle and hold until the next REPORT.
  - Then go to HOLD.
- Latency: first hit sampled at edge t gives peak_valid_out high in the cycle following edge t+WIN_LEN.
- HOLD: count HOLDOFF cycles, ignoring success. Then go to ARMED if search_arm_in=1, else IDLE.
- Arm deassert:
  - In ARMED or SEARCH: next state IDLE; window discarded; no strobe; report outputs keep their old values.
  - REPORT always completes its strobe.
  - HOLD finishes its count, then goes to IDLE.
- WIN_LEN=1: SEARCH is skipped; ARMED goes straight to REPORT.
- correlate_peak_in is ignored whenever success=0.
- Timestamp wrap is not special-cased.

Decomposition:
- Package coarse_sync_pkg: state enum, PEAK_W=11, default TS_W, HIT_W=8, saturation constant.
- One sub-module peak_tracker: clear/load/compare-and-hold of max value, offset and time, plus the saturating hit counter.
- The FSM, timestamp and timeout counter stay in the top.

Test Plan:
1. Arm; hits at offsets 0 (peak 300), 5 (500), 10 (500) -> one strobe 64 cycles after the first hit; value 500, offset 5, time = first-hit timestamp + 5, hits 3.
2. Arm, timeout=1000, no hits -> sync_timeout_out pulses at 1000 and 2000 cycles after ARMED entry; search_busy_out stays 1; no peak_valid_out.
3. Arm; first hit; drop arm at offset 20 -> no strobe; search_busy_out=0 the next cycle; report outputs unchanged.
4. After a report, hits during the 256 HOLD cycles are ignored -> the first hit after HOLD opens a new window and produces a second report with offset measured from that hit.
5. Assert reset at offset 30 of a window -> all outputs 0 immediately; after release and re-arm, normal search resumes.
6. WIN_LEN=1 build; single hit peak 77 -> peak_valid_out in the next cycle with value 77, offset 0, hits 1.
